// File: rtl/i2c_master_arb_if.sv
// rtl/i2c_master_arb_if.sv - requester-side and i2c_master-side streams of the arbiter
// The master modport is the arbiter's view; slave is the surrounding requesters plus i2c_master.
interface i2c_master_arb_if #(
  parameter int PORTS = 2
);
  logic [PORTS*7-1:0] s_cmd_address;
  logic [PORTS-1:0]   s_cmd_start;
  logic [PORTS-1:0]   s_cmd_read;
  logic [PORTS-1:0]   s_cmd_write;
  logic [PORTS-1:0]   s_cmd_write_multiple;
  logic [PORTS-1:0]   s_cmd_stop;
  logic [PORTS-1:0]   s_cmd_valid;
  logic [PORTS-1:0]   s_cmd_ready;
  logic [PORTS*8-1:0] s_data_in;
  logic [PORTS-1:0]   s_data_in_valid;
  logic [PORTS-1:0]   s_data_in_last;
  logic [PORTS-1:0]   s_data_in_ready;
  logic [7:0]         s_data_out;
  logic [PORTS-1:0]   s_data_out_valid;
  logic [PORTS-1:0]   s_data_out_ready;
  logic [6:0]         m_cmd_address;
  logic               m_cmd_start;
  logic               m_cmd_read;
  logic               m_cmd_write;
  logic               m_cmd_write_multiple;
  logic               m_cmd_stop;
  logic               m_cmd_valid;
  logic               m_cmd_ready;
  logic [7:0]         m_data_in;
  logic               m_data_in_valid;
  logic               m_data_in_last;
  logic               m_data_in_ready;
  logic [7:0]         m_data_out;
  logic               m_data_out_valid;
  logic               m_data_out_ready;

  modport master (
    input  s_cmd_address, s_cmd_start, s_cmd_read, s_cmd_write, s_cmd_write_multiple,
           s_cmd_stop, s_cmd_valid, s_data_in, s_data_in_valid, s_data_in_last,
           s_data_out_ready, m_cmd_ready, m_data_in_ready, m_data_out, m_data_out_valid,
    output s_cmd_ready, s_data_in_ready, s_data_out, s_data_out_valid,
           m_cmd_address, m_cmd_start, m_cmd_read, m_cmd_write, m_cmd_write_multiple,
           m_cmd_stop, m_cmd_valid, m_data_in, m_data_in_valid, m_data_in_last,
           m_data_out_ready
  );

  modport slave (
    output s_cmd_address, s_cmd_start, s_cmd_read, s_cmd_write, s_cmd_write_multiple,
           s_cmd_stop, s_cmd_valid, s_data_in, s_data_in_valid, s_data_in_last,
           s_data_out_ready, m_cmd_ready, m_data_in_ready, m_data_out, m_data_out_valid,
    input  s_cmd_ready, s_data_in_ready, s_data_out, s_data_out_valid,
           m_cmd_address, m_cmd_start, m_cmd_read, m_cmd_write, m_cmd_write_multiple,
           m_cmd_stop, m_cmd_valid, m_data_in, m_data_in_valid, m_data_in_last,
           m_data_out_ready
  );
endinterface

// File: rtl/i2c_master_arb.sv
// rtl/i2c_master_arb.sv - transaction-atomic round-robin arbiter in front of one i2c_master
// A grant is held from the first command until the stop-terminated transfer drains or times out.
module i2c_master_arb #(
  parameter int PORTS   = 2,
  parameter int TIMEOUT = 1024,
  parameter int CW      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  i2c_master_arb_if.master bus,
  output logic [PORTS-1:0] grant,
  output logic             busy,
  output logic             timeout_err
);
  localparam int IW = (PORTS > 1) ? $clog2(PORTS) : 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;
  typedef enum logic [1:0] {W_LAST, W_WR, W_RD} wait_t;

  state_t           state_q;
  wait_t            wait_q;
  logic [PORTS-1:0] grant_q;
  logic [IW-1:0]    gidx_q;
  logic [IW-1:0]    ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             terr_q;
  logic             out_en_q;

  logic [IW-1:0]    pick_d;
  logic [IW-1:0]    idx;
  logic             found;
  logic             cmd_acc, wr_acc, rd_acc, any_acc;
  logic             beat_done, tmo, rel;

  // Round-robin search starting one past the last owner.
  always_comb begin
    found  = 1'b0;
    pick_d = ptr_q;
    idx    = ptr_q;
    for (int k = 0; k < PORTS; k++) begin
      idx = (idx == IW'(PORTS - 1)) ? '0 : idx + 1'b1;
      if (!found && bus.s_cmd_valid[idx]) begin
        found  = 1'b1;
        pick_d = idx;
      end
    end
  end

  always_comb begin
    bus.m_cmd_address        = '0;
    bus.m_cmd_start          = 1'b0;
    bus.m_cmd_read           = 1'b0;
    bus.m_cmd_write          = 1'b0;
    bus.m_cmd_write_multiple = 1'b0;
    bus.m_cmd_stop           = 1'b0;
    bus.m_cmd_valid          = 1'b0;
    bus.m_data_in            = '0;
    bus.m_data_in_valid      = 1'b0;
    bus.m_data_in_last       = 1'b0;
    bus.s_cmd_ready          = '0;
    bus.s_data_in_ready      = '0;
    bus.s_data_out_valid     = '0;
    bus.s_data_out           = bus.m_data_out;
    // out_en_q keeps this low while in reset; stray read data is otherwise swallowed in IDLE.
    bus.m_data_out_ready     = out_en_q;
    if (state_q != IDLE) begin
      bus.m_cmd_address                = bus.s_cmd_address[7*int'(gidx_q) +: 7];
      bus.m_cmd_start                  = bus.s_cmd_start[gidx_q];
      bus.m_cmd_read                   = bus.s_cmd_read[gidx_q];
      bus.m_cmd_write                  = bus.s_cmd_write[gidx_q];
      bus.m_cmd_write_multiple         = bus.s_cmd_write_multiple[gidx_q];
      bus.m_cmd_stop                   = bus.s_cmd_stop[gidx_q];
      bus.m_cmd_valid                  = bus.s_cmd_valid[gidx_q];
      bus.s_cmd_ready[gidx_q]          = bus.m_cmd_ready;
      bus.m_data_in                    = bus.s_data_in[8*int'(gidx_q) +: 8];
      bus.m_data_in_valid              = bus.s_data_in_valid[gidx_q];
      bus.m_data_in_last               = bus.s_data_in_last[gidx_q];
      bus.s_data_in_ready[gidx_q]      = bus.m_data_in_ready;
      bus.s_data_out_valid[gidx_q]     = bus.m_data_out_valid;
      bus.m_data_out_ready             = bus.s_data_out_ready[gidx_q];
    end
  end

  assign cmd_acc   = bus.m_cmd_valid & bus.m_cmd_ready;
  assign wr_acc    = bus.m_data_in_valid & bus.m_data_in_ready;
  assign rd_acc    = bus.m_data_out_valid & bus.m_data_out_ready;
  assign any_acc   = cmd_acc | wr_acc | rd_acc;
  assign beat_done = (wait_q == W_LAST) ? (wr_acc & bus.m_data_in_last) :
                     (wait_q == W_WR)   ? wr_acc : rd_acc;
  // A handshake in the compare cycle beats the timeout.
  assign tmo = (TIMEOUT != 0) && (state_q != IDLE) && (cnt_q >= CW'(TIMEOUT)) && !any_acc;
  assign rel = (state_q == ACTIVE && cmd_acc && bus.m_cmd_stop && !bus.m_cmd_write_multiple &&
                !bus.m_cmd_write && !bus.m_cmd_read) ||
               (state_q == DRAIN && beat_done);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wait_q   <= W_LAST;
      grant_q  <= '0;
      gidx_q   <= '0;
      ptr_q    <= IW'(PORTS - 1);
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      terr_q   <= 1'b0;
      out_en_q <= 1'b0;
    end else begin
      terr_q   <= 1'b0;
      out_en_q <= 1'b1;
      if (state_q == IDLE) begin
        cnt_q <= '0;
        if (found) begin
          state_q <= ACTIVE;
          grant_q <= {{(PORTS-1){1'b0}}, 1'b1} << pick_d;
          gidx_q  <= pick_d;
          busy_q  <= 1'b1;
        end
      end else if (tmo || rel) begin
        state_q <= IDLE;
        grant_q <= '0;
        ptr_q   <= gidx_q;
        cnt_q   <= '0;
        busy_q  <= 1'b0;
        terr_q  <= tmo;
      end else begin
        cnt_q <= any_acc ? '0 : ((&cnt_q) ? cnt_q : cnt_q + CW'(1));
        if (state_q == ACTIVE && cmd_acc && bus.m_cmd_stop) begin
          state_q <= DRAIN;
          wait_q  <= bus.m_cmd_write_multiple ? W_LAST : (bus.m_cmd_write ? W_WR : W_RD);
        end
      end
    end
  end

  assign grant       = grant_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;
endmodule

// File: tb/tb_i2c_master_arb.sv
// tb/tb_i2c_master_arb.sv - directed bench for i2c_master_arb
// dut_a runs without timeout, dut_b with TIMEOUT=8; both see the same stimulus.
module tb_i2c_master_arb;
  localparam int P  = 2;
  localparam int TO = 8;
  localparam logic [6:0] A0 = 7'h21;
  localparam logic [6:0] A1 = 7'h52;
  localparam logic [7:0] D0 = 8'hA5;
  localparam logic [7:0] D1 = 8'h3C;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i2c_master_arb_if #(.PORTS(P)) ifa ();
  i2c_master_arb_if #(.PORTS(P)) ifb ();

  logic [P-1:0] grant_a, grant_b;
  logic         busy_a, busy_b, terr_a, terr_b;

  i2c_master_arb #(.PORTS(P), .TIMEOUT(0), .CW(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa), .grant(grant_a), .busy(busy_a), .timeout_err(terr_a));
  i2c_master_arb #(.PORTS(P), .TIMEOUT(TO), .CW(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb), .grant(grant_b), .busy(busy_b), .timeout_err(terr_b));

  assign ifb.s_cmd_address        = ifa.s_cmd_address;
  assign ifb.s_cmd_start          = ifa.s_cmd_start;
  assign ifb.s_cmd_read           = ifa.s_cmd_read;
  assign ifb.s_cmd_write          = ifa.s_cmd_write;
  assign ifb.s_cmd_write_multiple = ifa.s_cmd_write_multiple;
  assign ifb.s_cmd_stop           = ifa.s_cmd_stop;
  assign ifb.s_cmd_valid          = ifa.s_cmd_valid;
  assign ifb.s_data_in            = ifa.s_data_in;
  assign ifb.s_data_in_valid      = ifa.s_data_in_valid;
  assign ifb.s_data_in_last       = ifa.s_data_in_last;
  assign ifb.s_data_out_ready     = ifa.s_data_out_ready;
  assign ifb.m_cmd_ready          = ifa.m_cmd_ready;
  assign ifb.m_data_in_ready      = ifa.m_data_in_ready;
  assign ifb.m_data_out           = ifa.m_data_out;
  assign ifb.m_data_out_valid     = ifa.m_data_out_valid;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clr_in();
    ifa.s_cmd_start          = '0;
    ifa.s_cmd_read           = '0;
    ifa.s_cmd_write          = '0;
    ifa.s_cmd_write_multiple = '0;
    ifa.s_cmd_stop           = '0;
    ifa.s_cmd_valid          = '0;
    ifa.s_data_in_valid      = '0;
    ifa.s_data_in_last       = '0;
    ifa.s_data_out_ready     = 2'b11;
    ifa.m_cmd_ready          = 1'b1;
    ifa.m_data_in_ready      = 1'b1;
    ifa.m_data_out_valid     = 1'b0;
    ifa.m_data_out           = 8'h9E;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clr_in();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [1:0] cv, stop, wm, dv, last;
    logic       mcr;
    logic [1:0] eg;
    logic       eb, emcv;
    logic [1:0] escr;
    logic       emdv, emlast;
    logic [1:0] esdr;
    logic       emdor;
  } vec_t;

  vec_t vecs[16];

  initial begin
    ifa.s_cmd_address = {A1, A0};
    ifa.s_data_in     = {D1, D0};
    clr_in();

    #12;
    chk("rst_grant", 32'(grant_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_terr", 32'(terr_a), 0);
    chk("rst_mcv", 32'(ifa.m_cmd_valid), 0);
    chk("rst_mdor", 32'(ifa.m_data_out_ready), 0);
    chk("rst_scr", 32'(ifa.s_cmd_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // cv stop wm dv last mcr | grant busy mcv scr mdv mlast sdr mdor
    vecs[0]  = '{2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1};
    vecs[1]  = '{2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 2'b01, 1'b1};
    vecs[2]  = vecs[0];
    vecs[3]  = '{2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 1'b1, 2'b10, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 2'b10, 1'b1};
    vecs[4]  = vecs[0];
    vecs[5]  = vecs[1];
    vecs[6]  = vecs[0];
    vecs[7]  = vecs[3];
    vecs[8]  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1};
    vecs[9]  = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1};
    vecs[10] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 2'b01, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 2'b01, 1'b1};
    vecs[11] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 1'b1, 2'b01, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 2'b01, 1'b1};
    vecs[12] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 1'b1, 2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 2'b01, 1'b1};
    vecs[13] = vecs[12];
    vecs[14] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 1'b1, 2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 2'b01, 1'b1};
    vecs[15] = vecs[8];

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      ifa.s_cmd_valid          = vecs[i].cv;
      ifa.s_cmd_start          = vecs[i].cv;
      ifa.s_cmd_stop           = vecs[i].stop;
      ifa.s_cmd_write_multiple = vecs[i].wm;
      ifa.s_data_in_valid      = vecs[i].dv;
      ifa.s_data_in_last       = vecs[i].last;
      ifa.m_cmd_ready          = vecs[i].mcr;
      #1;
      chk($sformatf("v%0d_grant", i), 32'(grant_a), 32'(vecs[i].eg));
      chk($sformatf("v%0d_busy", i), 32'(busy_a), 32'(vecs[i].eb));
      chk($sformatf("v%0d_mcv", i), 32'(ifa.m_cmd_valid), 32'(vecs[i].emcv));
      chk($sformatf("v%0d_scr", i), 32'(ifa.s_cmd_ready), 32'(vecs[i].escr));
      chk($sformatf("v%0d_mdv", i), 32'(ifa.m_data_in_valid), 32'(vecs[i].emdv));
      chk($sformatf("v%0d_mlast", i), 32'(ifa.m_data_in_last), 32'(vecs[i].emlast));
      chk($sformatf("v%0d_sdr", i), 32'(ifa.s_data_in_ready), 32'(vecs[i].esdr));
      chk($sformatf("v%0d_mdor", i), 32'(ifa.m_data_out_ready), 32'(vecs[i].emdor));
      if (vecs[i].emcv)
        chk($sformatf("v%0d_addr", i), 32'(ifa.m_cmd_address), 32'((vecs[i].eg == 2'b01) ? A0 : A1));
      if (vecs[i].emdv)
        chk($sformatf("v%0d_wdata", i), 32'(ifa.m_data_in), 32'((vecs[i].eg == 2'b01) ? D0 : D1));
    end

    // Port1 two-part read while port0 keeps requesting; last owner was port0.
    @(negedge clk);
    clr_in();
    ifa.s_cmd_valid = 2'b11;
    ifa.s_cmd_start = 2'b11;
    ifa.s_cmd_read  = 2'b10;
    ifa.s_cmd_stop  = 2'b01;
    #1 chk("rd_idle_grant", 32'(grant_a), 0);
    @(negedge clk); #1;
    chk("rd_grant", 32'(grant_a), 32'b10);
    chk("rd_scr", 32'(ifa.s_cmd_ready), 32'b10);
    chk("rd_addr", 32'(ifa.m_cmd_address), 32'(A1));
    chk("rd_mstop", 32'(ifa.m_cmd_stop), 0);
    @(negedge clk);
    ifa.s_cmd_valid      = 2'b01;
    ifa.m_data_out_valid = 1'b1;
    ifa.m_data_out       = 8'h9E;
    #1;
    chk("rd1_grant", 32'(grant_a), 32'b10);
    chk("rd1_blk0", 32'(ifa.s_cmd_ready[0]), 0);
    chk("rd1_sdov", 32'(ifa.s_data_out_valid), 32'b10);
    chk("rd1_data", 32'(ifa.s_data_out), 32'h9E);
    @(negedge clk);
    ifa.m_data_out_valid = 1'b0;
    ifa.s_cmd_valid      = 2'b11;
    ifa.s_cmd_stop       = 2'b11;
    #1;
    chk("rd2c_grant", 32'(grant_a), 32'b10);
    chk("rd2c_blk0", 32'(ifa.s_cmd_ready[0]), 0);
    chk("rd2c_mstop", 32'(ifa.m_cmd_stop), 1);
    @(negedge clk);
    ifa.s_cmd_valid = 2'b01;
    ifa.s_cmd_stop  = 2'b01;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("rdw_grant", 32'(grant_a), 32'b10);
      chk("rdw_blk0", 32'(ifa.s_cmd_ready[0]), 0);
      @(negedge clk);
    end
    ifa.m_data_out_valid = 1'b1;
    ifa.m_data_out       = 8'h4B;
    #1;
    chk("rd2_sdov", 32'(ifa.s_data_out_valid), 32'b10);
    chk("rd2_data", 32'(ifa.s_data_out), 32'h4B);
    chk("rd2_grant", 32'(grant_a), 32'b10);
    @(negedge clk);
    ifa.m_data_out_valid = 1'b0;
    #1;
    chk("rdrel_grant", 32'(grant_a), 0);
    chk("rdrel_busy", 32'(busy_a), 0);
    @(negedge clk); #1;
    chk("p0_grant", 32'(grant_a), 32'b01);
    chk("p0_scr", 32'(ifa.s_cmd_ready), 32'b01);
    @(negedge clk);
    ifa.s_cmd_valid = 2'b00;
    #1 chk("p0_rel", 32'(grant_a), 0);

    // Hold timeout on dut_b: port0 goes silent while port1 waits.
    do_reset();
    ifa.s_cmd_valid = 2'b11;
    @(negedge clk);
    ifa.s_cmd_valid = 2'b10;
    #1;
    chk("to_grant0", 32'(grant_b), 32'b01);
    chk("to_terr0", 32'(terr_b), 0);
    for (int i = 1; i <= TO; i++) begin
      @(negedge clk); #1;
      chk($sformatf("to_hold%0d", i), 32'(grant_b), 32'b01);
      chk($sformatf("to_terr%0d", i), 32'(terr_b), 0);
    end
    @(negedge clk); #1;
    chk("to_rel_grant", 32'(grant_b), 0);
    chk("to_pulse", 32'(terr_b), 1);
    chk("to_rel_busy", 32'(busy_b), 0);
    chk("to_a_hold", 32'(grant_a), 32'b01);
    chk("to_a_terr", 32'(terr_a), 0);
    @(negedge clk); #1;
    chk("to_next_grant", 32'(grant_b), 32'b10);
    chk("to_pulse_end", 32'(terr_b), 0);

    // Read drain stalled by the requester with no timeout on dut_a.
    do_reset();
    ifa.s_cmd_valid      = 2'b01;
    ifa.s_cmd_start      = 2'b01;
    ifa.s_cmd_read       = 2'b01;
    ifa.s_cmd_stop       = 2'b01;
    ifa.s_data_out_ready = 2'b00;
    @(negedge clk); #1;
    chk("st_grant", 32'(grant_a), 32'b01);
    @(negedge clk);
    ifa.s_cmd_valid      = 2'b00;
    ifa.m_data_out_valid = 1'b1;
    #1 chk("st_sdov", 32'(ifa.s_data_out_valid), 32'b01);
    for (int i = 0; i < 20; i++) begin
      #1;
      chk($sformatf("st_grant%0d", i), 32'(grant_a), 32'b01);
      chk($sformatf("st_mdor%0d", i), 32'(ifa.m_data_out_ready), 0);
      @(negedge clk);
    end
    chk("st_terr", 32'(terr_a), 0);
    ifa.s_data_out_ready = 2'b01;
    #1 chk("st_mdor_up", 32'(ifa.m_data_out_ready), 1);
    @(negedge clk);
    ifa.m_data_out_valid = 1'b0;
    #1;
    chk("st_rel_grant", 32'(grant_a), 0);
    chk("st_rel_busy", 32'(busy_a), 0);

    // Asynchronous reset in the middle of DRAIN.
    do_reset();
    ifa.s_cmd_valid      = 2'b01;
    ifa.s_cmd_start      = 2'b01;
    ifa.s_cmd_read       = 2'b01;
    ifa.s_cmd_stop       = 2'b01;
    ifa.s_data_out_ready = 2'b00;
    @(negedge clk);
    @(negedge clk);
    ifa.s_cmd_valid      = 2'b00;
    ifa.m_data_out_valid = 1'b1;
    ifa.s_data_in_valid  = 2'b01;
    #1;
    chk("ar_pre_busy", 32'(busy_a), 1);
    chk("ar_pre_sdr", 32'(ifa.s_data_in_ready), 32'b01);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_grant", 32'(grant_a), 0);
    chk("ar_busy", 32'(busy_a), 0);
    chk("ar_mdor", 32'(ifa.m_data_out_ready), 0);
    chk("ar_sdov", 32'(ifa.s_data_out_valid), 0);
    chk("ar_sdr", 32'(ifa.s_data_in_ready), 0);
    chk("ar_scr", 32'(ifa.s_cmd_ready), 0);
    chk("ar_mdv", 32'(ifa.m_data_in_valid), 0);
    clr_in();
    ifa.s_cmd_valid = 2'b11;
    ifa.s_cmd_stop  = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("ar_first_grant", 32'(grant_a), 32'b01);
    @(negedge clk);
    ifa.s_cmd_valid = 2'b00;
    #1 chk("ar_first_rel", 32'(grant_a), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_master_arb.md
Name: i2c_master_arb

Overview:
- Round-robin arbiter sharing one i2c_master command/data stream interface between PORTS requesters (e.g. i2c_init plus run-time register access).
- Grants are transaction-atomic: one requester owns the master from its first accepted command until its stop-terminated transaction has fully drained.
- Sits between the requesters and the single i2c_master instance. Provides a hold timeout so a stalled owner cannot lock the bus.

Parameters:
- PORTS, 2, number of requesters (2..8).
- TIMEOUT, 1024, idle cycles allowed while holding a grant; 0 disables the timeout.
- CW, 16, idle counter width; must satisfy TIMEOUT < 2**CW.

Ports:
- clk in 1: clock.
- rst_n in 1: reset; one clock, asynchronous assert, active-low.
- s_cmd_address in PORTS*7: per-port address, port i at [7i+6:7i].
- s_cmd_start/s_cmd_read/s_cmd_write/s_cmd_write_multiple/s_cmd_stop in PORTS each: per-port command flags.
- s_cmd_valid in PORTS, s_cmd_ready out PORTS: per-port command handshake.
- s_data_in in PORTS*8, s_data_in_valid in PORTS, s_data_in_last in PORTS, s_data_in_ready out PORTS: write data toward the master.
- s_data_out out 8 (shared bus), s_data_out_valid out PORTS, s_data_out_ready in PORTS: read data toward the requester.
- m_cmd_address out 7, m_cmd_start/read/write/write_multiple/stop out 1 each, m_cmd_valid out 1, m_cmd_ready in 1: master command interface.
- m_data_in out 8, m_data_in_valid out 1, m_data_in_last out 1, m_data_in_ready in 1: master write data.
- m_data_out in 8, m_data_out_valid in 1, m_data_out_ready out 1: master read data.
- grant out PORTS: one-hot owner; 0 when idle.
- busy out 1: asserted when the state is not IDLE.
- timeout_err out 1: single-cycle pulse on a forced release.

Behaviour:
- States are IDLE, ACTIVE, DRAIN. Reset gives state=IDLE, grant=0, last-grant pointer=PORTS-1, idle counter=0, busy=0, timeout_err=0, and all ready/valid outputs 0.
- IDLE:
  - All s_*_ready=0 and m_cmd_valid=0; m_data_out_ready=1 (stray read data is discarded).
  - If any s_cmd_valid is set, grant goes to the first requesting port searching from last+1 upward with wrap. The state moves to ACTIVE on the next edge, giving 1 cycle of arbitration latency. No command passes in the grant cycle.
- ACTIVE and DRAIN routing is purely combinational for the granted port g:
  - m_cmd_* = s_cmd_*[g], and s_cmd_ready[g] = m_cmd_ready.
  - m_data_in* = s_data_in*[g], and s_data_in_ready[g] = m_data_in_ready.
  - s_data_out_valid[g] = m_data_out_valid, and m_data_out_ready = s_data_out_ready[g].
  - Non-granted ports see ready=0 and valid=0.
  - s_data_out always equals m_data_out.
- ACTIVE exit on accepting a command with stop=1 (m_cmd_valid & m_cmd_ready & m_cmd_stop):
  - write_multiple: go to DRAIN, waiting for an accepted write beat with last=1.
  - write (single): go to DRAIN, waiting for any accepted write beat.
  - read: go to DRAIN, waiting for an accepted read beat.
  - No read/write flags (pure stop): go to IDLE directly.
  - Flag priority is write_multiple > write > read.
  - A command without stop keeps the grant (repeated-start sequences stay atomic).
- DRAIN: when the awaited beat is accepted, go to IDLE on that edge. The next arbitration may be won in the following cycle.
- Leaving to IDLE: grant clears, and the last-grant pointer updates to g.
- Idle counter:
  - Active in ACTIVE/DRAIN. It clears on any accepted cmd/write/read beat, otherwise increments, saturating at all-ones.
  - When TIMEOUT≠0 and the counter reaches TIMEOUT: go to IDLE and pulse timeout_err for 1 cycle. The pointer still updates.
  - The counter clears on entering IDLE.
- A handshake completing in the same cycle as the timeout compare takes precedence: the counter clears and no timeout occurs.
- Async reset mid-transaction returns to IDLE immediately and all outputs drop. The i2c_master is reset alongside, so no bus recovery is needed here.
- One command per grant path; there is no buffering, so arbiter latency adds 0 cycles beyond the grant cycle.

Test Plan:
- PORTS=2, only port0 issues a write_multiple+stop of 3 bytes:
  - grant=01 one cycle after cmd_valid; command forwarded unchanged.
  - Release in the cycle after the last=1 beat is accepted; busy falls.
- Both ports assert cmd_valid in the same cycle after reset:
  - port0 is granted first (pointer=1); port1 is granted after port0's pure-stop command.
  - Repeated continuously: strict alternation 01,10,01,10.
- Port1 runs a read (start, no stop) followed by read+stop, while port0 keeps cmd_valid high:
  - port0 is blocked throughout (s_cmd_ready[0]=0).
  - The grant is held until the second read byte is accepted by port1.
- TIMEOUT=8, port0 granted, then all valids drop:
  - timeout_err pulses on the idle cycle where the count reaches 8; grant=0.
  - Pending port1 is granted next.
- Port0 read+stop with s_data_out_ready[0] held low for 20 cycles (TIMEOUT=0):
  - Remains in DRAIN, m_data_out_ready=0; releases when ready rises.
- Assert rst_n low mid-DRAIN:
  - grant, busy and all valid/ready outputs go to 0 asynchronously.
  - After release, the first arbitration starts from port0.
